// File: rtl/cmd_issue_stage_5b.sv
// Command issue stage: captures a one-hot grant from the look-ahead priority encoder,
// presents the payload on a valid/ready bus, acks the source queue and enforces an idle gap.
module cmd_issue_stage_5b #(
  parameter int CMD_W   = 32,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         grant_onehot,
  input  logic [5*CMD_W-1:0] cmd_in,
  output logic               look_ahead,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [CMD_W-1:0]   cmd_data,
  output logic [2:0]         cmd_src,
  output logic [4:0]         ack_out,
  output logic [CNT_W-1:0]   issue_cnt,
  output logic               onehot_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Reload value after a handshake; only used when GAP_CYC is nonzero.
  localparam logic [3:0] GAP_LOAD = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

  state_t             state, state_nxt;
  logic [3:0]         gap_cnt;
  logic               grant_single;
  logic               grant_multi;
  logic [2:0]         sel_src;
  logic [CMD_W-1:0]   sel_data;
  logic               handshake;

  assign grant_single = (grant_onehot != 5'd0) &&
                        ((grant_onehot & (grant_onehot - 5'd1)) == 5'd0);
  assign grant_multi  = (grant_onehot != 5'd0) && !grant_single;
  assign handshake    = (state == HOLD) && cmd_ready;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel_src  = 3'd0;
    sel_data = '0;
    for (int i = 0; i < 5; i++) begin
      if (grant_onehot[i]) begin
        sel_src  = 3'(i);
        sel_data = cmd_in[i*CMD_W +: CMD_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_single) state_nxt = HOLD;
      HOLD: if (cmd_ready) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // look_ahead depends only on state, keeping the encoder path free of combinational loops.
  always_comb begin
    look_ahead = (state == IDLE);
    cmd_valid  = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_data   <= '0;
      cmd_src    <= 3'd0;
      ack_out    <= 5'd0;
      issue_cnt  <= '0;
      onehot_err <= 1'b0;
      gap_cnt    <= 4'd0;
    end else begin
      ack_out <= 5'd0;
      case (state)
        IDLE: begin
          if (grant_single) begin
            cmd_data <= sel_data;
            cmd_src  <= sel_src;
            ack_out  <= grant_onehot;
          end else if (grant_multi) begin
            onehot_err <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            issue_cnt <= issue_cnt + 1'b1;
            gap_cnt   <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_issue_stage_5b.sv
// Bench for cmd_issue_stage_5b: two instances (gap 2 / 16-bit count, gap 0 / 4-bit count)
// share stimulus and are compared every cycle against a cycle-countdown reference model.
module tb_cmd_issue_stage_5b;

  localparam int CMD_W = 32;

  typedef struct {
    logic            valid;
    logic [31:0]     data;
    logic [2:0]      src;
    logic [4:0]      ack;
    int unsigned     cnt;
    logic            err;
    int              wait_c;
  } model_t;

  typedef struct {
    logic        la;
    logic        valid;
    logic [31:0] data;
    logic [2:0]  src;
    logic [4:0]  ack;
    logic [15:0] cnt;
    logic        err;
  } obs_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [4:0]         grant_onehot = 5'd0;
  logic [5*CMD_W-1:0] cmd_in = '0;
  logic               cmd_ready = 1'b0;

  logic        la0, v0, e0, la1, v1, e1;
  logic [31:0] d0, d1;
  logic [2:0]  s0, s1;
  logic [4:0]  a0, a1;
  logic [15:0] c0;
  logic [3:0]  c1;

  int checks   = 0;
  int failures = 0;

  model_t mdl [2];
  int     gap_of [2] = '{2, 0};
  int     cw_of  [2] = '{16, 4};

  cmd_issue_stage_5b #(.CMD_W(CMD_W), .GAP_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .grant_onehot(grant_onehot), .cmd_in(cmd_in),
    .look_ahead(la0), .cmd_valid(v0), .cmd_ready(cmd_ready), .cmd_data(d0),
    .cmd_src(s0), .ack_out(a0), .issue_cnt(c0), .onehot_err(e0)
  );

  cmd_issue_stage_5b #(.CMD_W(CMD_W), .GAP_CYC(0), .CNT_W(4)) dut_g0 (
    .clk(clk), .rst(rst), .grant_onehot(grant_onehot), .cmd_in(cmd_in),
    .look_ahead(la1), .cmd_valid(v1), .cmd_ready(cmd_ready), .cmd_data(d1),
    .cmd_src(s1), .ack_out(a1), .issue_cnt(c1), .onehot_err(e1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.valid = 1'b0; m.data = '0; m.src = '0; m.ack = '0;
    m.cnt = 0; m.err = 1'b0; m.wait_c = 0;
    return m;
  endfunction

  // One clock of the reference behaviour: a command is either outstanding, or the stage is
  // waiting out idle cycles, or it is free to take a single-bit grant.
  function automatic model_t model_step(input model_t m, input int gap, input logic [4:0] g,
                                        input logic [5*CMD_W-1:0] cin, input logic rdy);
    m.ack = 5'd0;
    if (m.valid) begin
      if (rdy) begin
        m.valid  = 1'b0;
        m.cnt    = m.cnt + 1;
        m.wait_c = gap;
      end
    end else if (m.wait_c > 0) begin
      m.wait_c = m.wait_c - 1;
    end else if ($countones(g) == 1) begin
      for (int i = 0; i < 5; i++)
        if (g[i]) begin
          m.src  = 3'(i);
          m.data = cin[i*CMD_W +: CMD_W];
        end
      m.valid = 1'b1;
      m.ack   = g;
    end else if ($countones(g) > 1) begin
      m.err = 1'b1;
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) mdl[k] = model_reset();
      else     mdl[k] = model_step(mdl[k], gap_of[k], grant_onehot, cmd_in, cmd_ready);
    end
  end

  always @(negedge clk) begin
    obs_t o [2];
    if (!rst) begin
      o[0] = '{la0, v0, d0, s0, a0, c0, e0};
      o[1] = '{la1, v1, d1, s1, a1, {12'd0, c1}, e1};
      for (int k = 0; k < 2; k++) begin
        int unsigned mask;
        mask = (32'd1 << cw_of[k]) - 32'd1;
        check($sformatf("look_ahead[%0d]", k), 64'(o[k].la),
              64'(!mdl[k].valid && mdl[k].wait_c == 0));
        check($sformatf("cmd_valid[%0d]", k), 64'(o[k].valid), 64'(mdl[k].valid));
        check($sformatf("ack_out[%0d]", k), 64'(o[k].ack), 64'(mdl[k].ack));
        check($sformatf("issue_cnt[%0d]", k), 64'(o[k].cnt), 64'(mdl[k].cnt & mask));
        check($sformatf("onehot_err[%0d]", k), 64'(o[k].err), 64'(mdl[k].err));
        if (mdl[k].valid) begin
          check($sformatf("cmd_data[%0d]", k), 64'(o[k].data), 64'(mdl[k].data));
          check($sformatf("cmd_src[%0d]", k), 64'(o[k].src), 64'(mdl[k].src));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    grant_onehot = 5'd0;
    cmd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    do_reset();
    check("reset look_ahead", 64'(la0), 64'd1);
    check("reset cmd_valid", 64'(v0), 64'd0);
    check("reset issue_cnt", 64'(c0), 64'd0);

    // Single grant on slot 2 with ready high.
    grant_onehot = 5'b00100;
    cmd_in[2*CMD_W +: CMD_W] = 32'hDEADBEEF;
    cmd_ready = 1'b1;
    tick();
    grant_onehot = 5'd0;
    check("t1 valid", 64'(v0), 64'd1);
    check("t1 data", 64'(d0), 64'hDEADBEEF);
    check("t1 src", 64'(s0), 64'd2);
    check("t1 ack", 64'(a0), 64'b00100);
    check("t1 la during hold", 64'(la0), 64'd0);
    tick();
    check("t1 cnt", 64'(c0), 64'd1);
    check("t1 ack cleared", 64'(a0), 64'd0);
    check("t1 gap la a", 64'(la0), 64'd0);
    tick();
    check("t1 gap la b", 64'(la0), 64'd0);
    tick();
    check("t1 la back", 64'(la0), 64'd1);

    // Slot 0 held for six HOLD cycles by cmd_ready.
    cmd_ready = 1'b0;
    grant_onehot = 5'b00001;
    cmd_in[0 +: CMD_W] = 32'h1234_5678;
    tick();
    grant_onehot = 5'd0;
    cmd_in = '0;
    for (int j = 0; j < 6; j++) begin
      check("t2 valid", 64'(v0), 64'd1);
      check("t2 data", 64'(d0), 64'h1234_5678);
      check("t2 src", 64'(s0), 64'd0);
      check("t2 ack", 64'(a0), (j == 0) ? 64'b00001 : 64'd0);
      if (j == 5) cmd_ready = 1'b1;
      tick();
    end
    check("t2 cnt", 64'(c0), 64'd2);
    check("t2 valid low", 64'(v0), 64'd0);
    check("t2 data retained", 64'(d0), 64'h1234_5678);

    // Zero-gap instance: continuous slot-4 grant, capture every two cycles, 4-bit wrap.
    do_reset();
    grant_onehot = 5'b10000;
    cmd_in[4*CMD_W +: CMD_W] = 32'hA5A5_0004;
    cmd_ready = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      tick();
      if (j % 2 == 1) begin
        check("t3 ack", 64'(a1), 64'b10000);
        check("t3 src", 64'(s1), 64'd4);
      end
      if (j == 31) check("t3 cnt pre-wrap", 64'(c1), 64'd15);
    end
    check("t3 cnt wrapped", 64'(c1), 64'd0);

    // Multi-hot grant while idle sets the sticky error and captures nothing.
    grant_onehot = 5'd0;
    for (int j = 0; j < 4; j++) tick();
    grant_onehot = 5'b01010;
    tick();
    check("t4 err", 64'(e0), 64'd1);
    check("t4 no valid", 64'(v0), 64'd0);
    check("t4 no ack", 64'(a0), 64'd0);
    grant_onehot = 5'b00010;
    cmd_in[1*CMD_W +: CMD_W] = 32'h0BAD_F00D;
    tick();
    grant_onehot = 5'd0;
    check("t4 valid", 64'(v0), 64'd1);
    check("t4 src", 64'(s0), 64'd1);
    check("t4 ack", 64'(a0), 64'b00010);
    check("t4 err sticky", 64'(e0), 64'd1);

    // Asynchronous reset while a command is held.
    for (int j = 0; j < 4; j++) tick();
    cmd_ready = 1'b0;
    grant_onehot = 5'b00001;
    tick();
    grant_onehot = 5'd0;
    check("t5 in hold", 64'(v0), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t5 rst valid", 64'(v0), 64'd0);
    check("t5 rst ack", 64'(a0), 64'd0);
    check("t5 rst cnt", 64'(c0), 64'd0);
    check("t5 rst err", 64'(e0), 64'd0);
    check("t5 rst la", 64'(la0), 64'd1);
    tick();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      grant_onehot = 5'(1 << $urandom_range(0, 4));
      else if (r < 97) grant_onehot = 5'd0;
      else             grant_onehot = 5'($urandom_range(0, 31));
      for (int s = 0; s < 5; s++) cmd_in[s*CMD_W +: CMD_W] = $urandom;
      cmd_ready = ($urandom_range(0, 99) < 60);
      held = d0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
